// File: rtl/cache_tag_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl_pkg
// Shared definitions for the cache tag controllers: default address split,
// tag-entry field positions, controller state encoding and address helpers.
// ---------------------------------------------------------------------------
package cache_tag_ctrl_pkg;

    localparam int ADDR_W   = 64;
    localparam int INDEX_W  = 7;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    // Tag entry layout: {valid, dirty, tag}
    localparam int VALID_BIT = 54;
    localparam int DIRTY_BIT = 53;
    localparam int TAG_MSB   = 52;

    typedef enum logic [2:0] {
        S_SWEEP     = 3'd0,
        S_IDLE      = 3'd1,
        S_LOOKUP    = 3'd2,
        S_MISS_REQ  = 3'd3,
        S_MISS_WAIT = 3'd4,
        S_FILL      = 3'd5
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_tag_ctrl_cmp.sv
// ---------------------------------------------------------------------------
// cache_tag_cmp
// Combinational hit compare of one tag-array entry against a lookup tag.
// Ports:
//   i_entry  : {valid, dirty, tag} entry read from the array
//   i_tag    : tag of the address being looked up
//   o_hit    : entry is valid and its tag matches
// The dirty bit does not take part in the compare.
// ---------------------------------------------------------------------------
module cache_tag_cmp #(
    parameter int TAG_W = 53
) (
    input  logic [TAG_W+1:0] i_entry,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_hit
);

    logic w_valid;
    logic w_dirty_unused;

    assign w_valid        = i_entry[TAG_W+1];
    assign w_dirty_unused = i_entry[TAG_W];
    assign o_hit          = w_valid && (i_entry[TAG_W-1:0] == i_tag) && (w_dirty_unused | ~w_dirty_unused);

endmodule

// File: rtl/cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl
// Access-side controller for the 128-set cache tag array. Accepts one CPU
// lookup at a time, compares the stored entry, hands misses to the
// refill/writeback engine, installs the new tag, and runs an invalidate-all
// sweep after reset and on flush_req.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req_*                       lookup request (valid/ready, addr, store)
//   cpu_resp_valid / cpu_resp_hit   one-cycle response, hit or post-refill
//   tag_addr / tag_en / tag_wdata   array index and write port
//   tag_rdata                       combinational array read of tag_addr
//   refill_req_* / refill_addr      miss handoff
//   wb_valid / wb_addr              dirty victim writeback, with refill req
//   refill_done                     line data written by refill engine
//   flush_req / flush_done          invalidate-all request and completion
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SWEEP     | writing 0 into every set, one per cycle, index r_cnt
// IDLE      | ready for a lookup; flush_req takes priority
// LOOKUP    | array read of latched index, hit/miss decided this cycle
// MISS_REQ  | refill request (and victim writeback) offered to engine
// MISS_WAIT | refill engine busy, waiting for refill_done
// FILL      | new tag installed, miss response returned
// ---------------------------------------------------------------------------
module cache_tag_ctrl
    import cache_tag_ctrl_pkg::*;
#(
    parameter int ADDR_W   = cache_tag_ctrl_pkg::ADDR_W,
    parameter int INDEX_W  = cache_tag_ctrl_pkg::INDEX_W,
    parameter int OFFSET_W = cache_tag_ctrl_pkg::OFFSET_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     cpu_req_valid,
    output logic                                     cpu_req_ready,
    input  logic [ADDR_W-1:0]                        cpu_req_addr,
    input  logic                                     cpu_req_we,
    output logic                                     cpu_resp_valid,
    output logic                                     cpu_resp_hit,
    output logic [INDEX_W-1:0]                       tag_addr,
    output logic                                     tag_en,
    output logic [ADDR_W-INDEX_W-OFFSET_W+1:0]       tag_wdata,
    input  logic [ADDR_W-INDEX_W-OFFSET_W+1:0]       tag_rdata,
    output logic                                     refill_req_valid,
    input  logic                                     refill_req_ready,
    output logic [ADDR_W-1:0]                        refill_addr,
    output logic                                     wb_valid,
    output logic [ADDR_W-1:0]                        wb_addr,
    input  logic                                     refill_done,
    input  logic                                     flush_req,
    output logic                                     flush_done
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t              r_state;
    logic [INDEX_W-1:0]  r_cnt;
    logic                r_req_flag;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic                r_we;
    logic [TAG_W+1:0]    r_victim;

    logic                w_hit;
    logic                w_sweep_last;

    cache_tag_cmp #(.TAG_W(TAG_W)) u_cmp (
        .i_entry (tag_rdata),
        .i_tag   (r_tag),
        .o_hit   (w_hit)
    );

    assign w_sweep_last = (r_cnt == {INDEX_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SWEEP;
            r_cnt      <= '0;
            r_req_flag <= 1'b0;
            r_tag      <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_victim   <= '0;
        end else begin
            case (r_state)
                S_SWEEP: begin
                    r_cnt <= r_cnt + INDEX_W'(1);
                    if (w_sweep_last) begin
                        r_state    <= S_IDLE;
                        r_req_flag <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (flush_req) begin
                        r_state    <= S_SWEEP;
                        r_req_flag <= 1'b1;
                        r_cnt      <= '0;
                    end else if (cpu_req_valid) begin
                        r_tag   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
                        r_index <= cpu_req_addr[OFFSET_W +: INDEX_W];
                        r_we    <= cpu_req_we;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= tag_rdata;
                        r_state  <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (refill_req_ready) begin
                        r_state <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (refill_done) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_SWEEP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decode from state; the hit path has to be combinational on
    // tag_rdata to answer in the lookup cycle. rst_n forces every output low
    // while reset is held, even though the state register already sits in
    // SWEEP.
    always_comb begin
        cpu_req_ready    = 1'b0;
        cpu_resp_valid   = 1'b0;
        cpu_resp_hit     = 1'b0;
        tag_addr         = r_index;
        tag_en           = 1'b0;
        tag_wdata        = '0;
        refill_req_valid = 1'b0;
        wb_valid         = 1'b0;
        flush_done       = 1'b0;
        refill_addr      = {r_tag, r_index, {OFFSET_W{1'b0}}};
        wb_addr          = {r_victim[TAG_W-1:0], r_index, {OFFSET_W{1'b0}}};

        case (r_state)
            S_SWEEP: begin
                tag_addr   = r_cnt;
                tag_en     = 1'b1;
                flush_done = w_sweep_last && r_req_flag;
            end
            S_IDLE: begin
                cpu_req_ready = !flush_req;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_hit   = 1'b1;
                    // Store to a clean resident line: set the dirty bit.
                    if (r_we && !tag_rdata[TAG_W]) begin
                        tag_en    = 1'b1;
                        tag_wdata = {2'b11, r_tag};
                    end
                end
            end
            S_MISS_REQ: begin
                refill_req_valid = 1'b1;
                wb_valid         = r_victim[TAG_W+1] && r_victim[TAG_W];
            end
            S_FILL: begin
                tag_en         = 1'b1;
                tag_wdata      = {1'b1, r_we, r_tag};
                cpu_resp_valid = 1'b1;
            end
            default: begin
            end
        endcase

        if (!rst_n) begin
            cpu_req_ready    = 1'b0;
            cpu_resp_valid   = 1'b0;
            cpu_resp_hit     = 1'b0;
            tag_addr         = '0;
            tag_en           = 1'b0;
            tag_wdata        = '0;
            refill_req_valid = 1'b0;
            wb_valid         = 1'b0;
            flush_done       = 1'b0;
            refill_addr      = '0;
            wb_addr          = '0;
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_tag_ctrl
// Directed bench for cache_tag_ctrl with a behavioural tag array and a
// response scoreboard (expected hit/miss pushed when a request is driven,
// popped when cpu_resp_valid appears).
// ---------------------------------------------------------------------------
module tb_cache_tag_ctrl;

    localparam int ADDR_W   = 64;
    localparam int INDEX_W  = 7;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    logic                 clk;
    logic                 rst_n;
    logic                 cpu_req_valid;
    logic                 cpu_req_ready;
    logic [ADDR_W-1:0]    cpu_req_addr;
    logic                 cpu_req_we;
    logic                 cpu_resp_valid;
    logic                 cpu_resp_hit;
    logic [INDEX_W-1:0]   tag_addr;
    logic                 tag_en;
    logic [TAG_W+1:0]     tag_wdata;
    logic [TAG_W+1:0]     tag_rdata;
    logic                 refill_req_valid;
    logic                 refill_req_ready;
    logic [ADDR_W-1:0]    refill_addr;
    logic                 wb_valid;
    logic [ADDR_W-1:0]    wb_addr;
    logic                 refill_done;
    logic                 flush_req;
    logic                 flush_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q[$];

    logic [TAG_W+1:0] mem [128];

    cache_tag_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_ready    (cpu_req_ready),
        .cpu_req_addr     (cpu_req_addr),
        .cpu_req_we       (cpu_req_we),
        .cpu_resp_valid   (cpu_resp_valid),
        .cpu_resp_hit     (cpu_resp_hit),
        .tag_addr         (tag_addr),
        .tag_en           (tag_en),
        .tag_wdata        (tag_wdata),
        .tag_rdata        (tag_rdata),
        .refill_req_valid (refill_req_valid),
        .refill_req_ready (refill_req_ready),
        .refill_addr      (refill_addr),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .refill_done      (refill_done),
        .flush_req        (flush_req),
        .flush_done       (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tag_rdata = mem[tag_addr];
    always @(posedge clk) begin
        if (tag_en) mem[tag_addr] <= tag_wdata;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:INDEX_W+OFFSET_W];
    endfunction

    // Response scoreboard
    always @(negedge clk) begin
        if (cpu_resp_valid) begin
            check("resp_expected_pending", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                logic e;
                e = exp_q.pop_front();
                check("resp_hit", cpu_resp_hit, e);
            end
        end
    end

    // One full sweep starting in the current cycle; flush_done expected on
    // the last cycle only when exp_done is set.
    task automatic run_sweep(input string tag, input logic exp_done);
        for (int i = 0; i < 128; i++) begin
            #1;
            check(tag, {cpu_req_ready, tag_en, tag_addr, tag_wdata, flush_done},
                       {1'b0, 1'b1, INDEX_W'(i), {(TAG_W+2){1'b0}}, (exp_done && i == 127)});
            nxt();
        end
    endtask

    // Drive a request in IDLE and run it through a miss with the refill
    // engine ready immediately; leaves the bench in the cycle after FILL.
    task automatic miss_flow(input logic [ADDR_W-1:0] a, input logic we,
                             input logic exp_wb, input logic [ADDR_W-1:0] exp_wb_addr);
        cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_we = we;
        exp_q.push_back(1'b0);
        #1 check("miss_accept_ready", cpu_req_ready, 1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("miss_lookup_no_write", {tag_en, refill_req_valid}, 2'b00);
        nxt();
        refill_req_ready = 1'b1;
        #1 check("miss_req", {refill_req_valid, refill_addr, wb_valid},
                            {1'b1, a[ADDR_W-1:OFFSET_W], 4'h0, exp_wb});
        if (exp_wb) check("miss_wb_addr", wb_addr, exp_wb_addr);
        nxt();
        refill_req_ready = 1'b0;
        #1 check("miss_wait_quiet", {refill_req_valid, cpu_resp_valid, tag_en}, 3'b000);
        nxt();
        refill_done = 1'b1;
        nxt();
        refill_done = 1'b0;
        #1 check("fill_write", {tag_en, tag_addr, tag_wdata},
                              {1'b1, a[OFFSET_W+:INDEX_W], 1'b1, we, tag_of(a)});
        nxt();
    endtask

    initial begin
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        a0 = 64'h0000_0000_8000_0010;
        a1 = 64'h0000_0000_9000_0010;

        rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
        refill_req_ready = 1'b0; refill_done = 1'b0; flush_req = 1'b0;

        repeat (3) nxt();
        #1 check("reset_outputs", {cpu_req_ready, tag_en, tag_addr, refill_req_valid, wb_valid,
                                   flush_done, cpu_resp_valid, refill_addr},
                                  {1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0});
        nxt();
        rst_n = 1'b1;
        run_sweep("sweep_reset", 1'b0);
        #1 check("idle_ready_after_sweep", cpu_req_ready, 1'b1);

        // Cold load miss: index 1 holds nothing yet
        miss_flow(a0, 1'b0, 1'b0, '0);

        // Repeat load hits
        cpu_req_valid = 1'b1; cpu_req_addr = a0; cpu_req_we = 1'b0;
        exp_q.push_back(1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("load_hit", {cpu_resp_valid, cpu_resp_hit, tag_en}, 3'b110);
        nxt();

        // Store hit to clean line upgrades to dirty
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1;
        exp_q.push_back(1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("store_upgrade", {cpu_resp_hit, tag_en, tag_wdata}, {1'b1, 1'b1, 2'b11, tag_of(a0)});
        nxt();

        // Second store: line already dirty, no write
        cpu_req_valid = 1'b1;
        exp_q.push_back(1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("store_dirty_no_write", {cpu_resp_hit, tag_en}, 2'b10);
        nxt();

        // refill_done outside MISS_WAIT is ignored
        refill_done = 1'b1;
        nxt();
        refill_done = 1'b0;
        #1 check("stray_refill_done", {cpu_req_ready, tag_en, cpu_resp_valid}, 3'b100);

        // Dirty eviction with refill engine stalled for 5 cycles
        cpu_req_valid = 1'b1; cpu_req_addr = a1; cpu_req_we = 1'b0;
        exp_q.push_back(1'b0);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("evict_lookup_miss", {cpu_resp_valid, tag_en}, 2'b00);
        nxt();
        for (int i = 0; i < 5; i++) begin
            #1 check("evict_hold", {refill_req_valid, wb_valid, wb_addr, refill_addr, cpu_req_ready},
                                   {1'b1, 1'b1, a0[ADDR_W-1:OFFSET_W], 4'h0,
                                    a1[ADDR_W-1:OFFSET_W], 4'h0, 1'b0});
            nxt();
        end
        refill_req_ready = 1'b1;
        nxt();
        refill_req_ready = 1'b0;
        #1 check("evict_wait", refill_req_valid, 1'b0);
        refill_done = 1'b1;
        nxt();
        refill_done = 1'b0;
        #1 check("evict_fill", {tag_en, tag_wdata}, {1'b1, 2'b10, tag_of(a1)});
        nxt();

        // Back-to-back hits on the new line: one response every 2 cycles
        cpu_req_valid = 1'b1; cpu_req_addr = a1;
        exp_q.push_back(1'b1);
        nxt();
        #1 check("b2b_hit0", {cpu_resp_valid, cpu_req_ready}, 2'b10);
        exp_q.push_back(1'b1);
        nxt();
        #1 check("b2b_accept1", cpu_req_ready, 1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("b2b_hit1", cpu_resp_valid, 1'b1);
        nxt();

        // Flush beats a simultaneous request
        flush_req = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = a1; cpu_req_we = 1'b0;
        #1 check("flush_blocks_ready", cpu_req_ready, 1'b0);
        nxt();
        flush_req = 1'b0;
        run_sweep("sweep_flush", 1'b1);
        // Held request now accepted; the line was invalidated so it misses
        exp_q.push_back(1'b0);
        #1 check("post_flush_ready", cpu_req_ready, 1'b1);
        nxt();
        cpu_req_valid = 1'b0;
        #1 check("post_flush_miss", {cpu_resp_valid, tag_en}, 2'b00);
        nxt();
        refill_req_ready = 1'b1;
        #1 check("post_flush_req", {refill_req_valid, wb_valid}, 2'b10);
        nxt();
        refill_req_ready = 1'b0;

        // Reset while in MISS_WAIT
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1 check("reset_mid_miss", {refill_req_valid, cpu_resp_valid, tag_en, cpu_req_ready}, 4'b0000);
        nxt();
        nxt();
        rst_n = 1'b1;
        refill_done = 1'b1;
        #1 check("reset_restart_idx0", {tag_en, tag_addr, cpu_resp_valid}, {1'b1, 7'd0, 1'b0});
        nxt();
        refill_done = 1'b0;
        #1 check("reset_restart_idx1", {tag_en, tag_addr, cpu_resp_valid}, {1'b1, 7'd1, 1'b0});
        nxt();
        for (int i = 2; i < 128; i++) begin
            #1 check("sweep_restart", {tag_en, tag_addr, flush_done}, {1'b1, INDEX_W'(i), 1'b0});
            nxt();
        end
        #1 check("final_idle", {cpu_req_ready, tag_en}, 2'b10);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
